// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, initial hash value,
// FSM encoding and the bitwise round/schedule functions.
package sha256_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WORD_W-1:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // H0..H7 packed in the same word order as mid_in / digest
  localparam logic [255:0] IV_ALL =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] shr(input logic [WORD_W-1:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [WORD_W-1:0] big_s0(input logic [WORD_W-1:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [WORD_W-1:0] big_s1(input logic [WORD_W-1:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [WORD_W-1:0] sm_s0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [WORD_W-1:0] sm_s1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule. W[0] is the word consumed by the
// current round; each shift appends the next expanded word at W[15].
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  input  logic [511:0]      block_in,
  output logic [WORD_W-1:0] wt
);

  logic [WORD_W-1:0] r_w [16];
  logic [WORD_W-1:0] w_next;

  // Expansion term; only meaningful up to round 48 but always computed
  always_comb begin
    w_next = sm_s1(r_w[14]) + r_w[9] + sm_s0(r_w[1]) + r_w[0];
  end

  // Load the block on accept, otherwise slide one word per round
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) r_w[i] <= block_in[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_next;
    end
  end

  assign wt = r_w[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// Iterative SHA-256 compression: one round per clock over ROUNDS cycles,
// then one FINAL cycle to form the digest.
// Build option: define SHA256_FEEDFORWARD_EN to add the midstate into the
// result; without it the raw working variables A..H are output.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic [255:0] mid_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest,
  output logic         busy
);

  state_t            r_state, w_state_nxt;
  logic [5:0]        r_cnt;
  logic [WORD_W-1:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [255:0]      r_digest;
`ifdef SHA256_FEEDFORWARD_EN
  logic [255:0]      r_mid;
`endif

  logic              w_accept, w_round, w_final, w_last;
  logic [WORD_W-1:0] w_kt, w_wt, w_t1, w_t2;
  logic [255:0]      w_result;

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_round  = (r_state == ST_ROUND);
  assign w_final  = (r_state == ST_FINAL);
  assign w_last   = (r_cnt == 6'(ROUNDS - 1));
  assign w_kt     = K_TAB[r_cnt];

  sha256_msg_sched u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_accept),
    .shift    (w_round),
    .block_in (block_in),
    .wt       (w_wt)
  );

  // Round arithmetic and the value the FINAL edge writes into the digest
  always_comb begin
    w_t1 = r_h + big_s1(r_e) + ch(r_e, r_f, r_g) + w_kt + w_wt;
    w_t2 = big_s0(r_a) + maj(r_a, r_b, r_c);
`ifdef SHA256_FEEDFORWARD_EN
    w_result = {r_mid[255:224] + r_a, r_mid[223:192] + r_b,
                r_mid[191:160] + r_c, r_mid[159:128] + r_d,
                r_mid[127:96]  + r_e, r_mid[95:64]   + r_f,
                r_mid[63:32]   + r_g, r_mid[31:0]    + r_h};
`else
    w_result = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};
`endif
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid)  w_state_nxt = ST_ROUND;
      ST_ROUND: if (w_last)    w_state_nxt = ST_FINAL;
      ST_FINAL:                w_state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Round counter: cleared on accept, saturates at the last round
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (w_accept)           r_cnt <= '0;
    else if (w_round && !w_last) r_cnt <= r_cnt + 6'd1;
  end

  // Working variables: seeded from the midstate, then one round per edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
    end else if (w_accept) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= mid_in;
    end else if (w_round) begin
      r_a <= w_t1 + w_t2;
      r_b <= r_a;
      r_c <= r_b;
      r_d <= r_c;
      r_e <= r_d + w_t1;
      r_f <= r_e;
      r_g <= r_f;
      r_h <= r_g;
    end
  end

`ifdef SHA256_FEEDFORWARD_EN
  // Chaining value kept for the final addition
  always_ff @(posedge clk) begin
    if (!rst_n)        r_mid <= '0;
    else if (w_accept) r_mid <= mid_in;
  end
`endif

  // Digest register: written once per block, held through backpressure
  always_ff @(posedge clk) begin
    if (!rst_n)       r_digest <= '0;
    else if (w_final) r_digest <= w_result;
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = w_round || w_final;
  assign digest    = r_digest;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: stimulus pushes expected digests
// and accept times, a monitor pops them when the engine presents a result.
// Expected values follow SHA256_FEEDFORWARD_EN when it is defined.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] block_in = '0;
  logic [255:0] mid_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] digest;
  logic         busy;

  sha256_round_ctrl #(.ROUNDS(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .block_in  (block_in),
    .mid_in    (mid_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [255:0] DIG_ABC   =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic         prev_ov  = 1'b0;
  logic [255:0] exp_q [$];
  int           acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Standard digest -> value this build presents (raw working vars = digest - IV)
  function automatic logic [255:0] adj(input logic [255:0] d);
    logic [255:0] r;
    logic [255:0] iv;
    r  = d;
    iv = IV_ALL;
`ifndef SHA256_FEEDFORWARD_EN
    for (int i = 0; i < 8; i++)
      r[255 - 32*i -: 32] = d[255 - 32*i -: 32] - iv[255 - 32*i -: 32];
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present a block and wait (bounded) for the handshake; returns accept cycle
  task automatic send(input logic [511:0] blk, input logic [255:0] mid,
                      input logic [255:0] exp, input bit push, input bit hold,
                      output int acc);
    int n;
    block_in = blk;
    mid_in   = mid;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!in_ready) begin
      chk("accept_timeout", {255'd0, in_ready}, 256'd1);
    end else if (push) begin
      exp_q.push_back(exp);
      acc_q.push_back(acc);
    end
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n;
    n = 0;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", {255'd0, out_valid}, 256'd1);
  endtask

  // Monitor: latency on out_valid rise, digest compare on handshake
  always @(negedge clk) begin
    #1;
    if (out_valid && !prev_ov) begin
      if (acc_q.size() == 0) chk("latency_unexpected", 256'd1, 256'd0);
      else chk("latency", 256'(cyc - acc_q.pop_front()), 256'd65);
    end
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("digest_unexpected", digest, 256'd0);
      else chk("digest", digest, exp_q.pop_front());
    end
  end

  initial begin
    int a1, a2, a3, n;
    logic [255:0] exp_abc;
    exp_abc = adj(DIG_ABC);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  {255'd0, in_ready},  256'd1);
    chk("rst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("rst_busy",      {255'd0, busy},      256'd0);
    chk("rst_digest",    digest,              256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" and empty message, consumer always ready
    out_ready = 1'b1;
    send(BLK_ABC,   IV_ALL, exp_abc,          1'b1, 1'b0, a1);
    send(BLK_EMPTY, IV_ALL, adj(DIG_EMPTY),   1'b1, 1'b0, a1);

    // Backpressure for 20 cycles
    send(BLK_ABC, IV_ALL, exp_abc, 1'b1, 1'b0, a1);
    out_ready = 1'b0;
    wait_ov();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_digest",    digest,              exp_abc);
      chk("bp_out_valid", {255'd0, out_valid}, 256'd1);
      chk("bp_in_ready",  {255'd0, in_ready},  256'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready",  {255'd0, in_ready},  256'd1);
    chk("bp_release_out_valid", {255'd0, out_valid}, 256'd0);

    // Reset in the middle of a block, then rerun "abc"
    send(BLK_ABC, IV_ALL, exp_abc, 1'b0, 1'b0, a1);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready",  {255'd0, in_ready},  256'd1);
    chk("midrst_out_valid", {255'd0, out_valid}, 256'd0);
    chk("midrst_busy",      {255'd0, busy},      256'd0);
    chk("midrst_digest",    digest,              256'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(BLK_ABC, IV_ALL, exp_abc, 1'b1, 1'b0, a1);

    // Back-to-back with in_valid held high
    send(BLK_ABC,   IV_ALL, exp_abc,        1'b1, 1'b1, a2);
    send(BLK_EMPTY, IV_ALL, adj(DIG_EMPTY), 1'b1, 1'b0, a3);
    chk("b2b_accept_gap", 256'(a3 - a2), 256'd67);

    // Random in_valid / block_in while rounds are running
    send(BLK_ABC, IV_ALL, exp_abc, 1'b1, 1'b0, a1);
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      for (int j = 0; j < 16; j++) block_in[511 - 32*j -: 32] = $urandom;
      for (int j = 0; j < 8; j++)  mid_in[255 - 32*j -: 32]   = $urandom;
      @(negedge clk);
    end
    chk("busy_during_round", {255'd0, busy}, 256'd1);
    in_valid = 1'b0;

    // Drain scoreboard
    n = 0;
    while ((exp_q.size() != 0 || acc_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_digests",   256'(exp_q.size()), 256'd0);
    chk("drain_latencies", 256'(acc_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
